// File: rtl/inst_slot_alloc.sv
// inst_slot_alloc: decodes RV32 instructions, allocates the lowest free buffer slot, and drives register fields to the dependency table
module inst_slot_alloc #(
    parameter int bs     = 32,
    parameter int regnum = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    output logic                     wr_en,
    output logic [$clog2(bs)-1:0]    buffer_index,
    output logic [$clog2(regnum)-1:0] rd,
    output logic [$clog2(regnum)-1:0] rs1,
    output logic [$clog2(regnum)-1:0] rs2,
    input  logic                     retire_valid,
    input  logic [$clog2(bs)-1:0]    retire_index,
    output logic [bs-1:0]            slot_valid,
    input  logic [$clog2(bs)-1:0]    rd_index,
    output logic [31:0]              rd_instr,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(bs):0]      count,
    output logic                     illegal
);
    localparam int idx_w = $clog2(bs);
    localparam int reg_w = $clog2(regnum);
    localparam int cnt_w = idx_w + 1;
    localparam logic [5:0] reg_lim = 6'(regnum);

    logic [31:0]      mem_q [bs];
    logic [bs-1:0]    slot_valid_q, slot_valid_d;
    logic [idx_w:0]   count_q, count_d;
    logic             wr_en_q, wr_en_d, illegal_q, illegal_d;
    logic [idx_w-1:0] buffer_index_q, buffer_index_d, free_idx;
    logic [reg_w-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [6:0]       opcode;
    logic [4:0]       f_rd, f_rs1, f_rs2;
    logic             use_rd, use_rs1, use_rs2, legal, accept, alloc, ret_hit;

    assign full         = &slot_valid_q;
    assign empty        = ~|slot_valid_q;
    assign in_ready     = !full;
    assign accept       = in_valid && in_ready;
    assign alloc        = accept && legal;
    assign ret_hit      = retire_valid && slot_valid_q[retire_index];
    assign rd_instr     = mem_q[rd_index];
    assign slot_valid   = slot_valid_q;
    assign count        = count_q;
    assign wr_en        = wr_en_q;
    assign illegal      = illegal_q;
    assign buffer_index = buffer_index_q;
    assign rd           = rd_q;
    assign rs1          = rs1_q;
    assign rs2          = rs2_q;

    // Field usage by opcode; any used field beyond the register file makes the instruction illegal
    always_comb begin
        opcode  = in_instr[6:0];
        f_rd    = in_instr[11:7];
        f_rs1   = in_instr[19:15];
        f_rs2   = in_instr[24:20];
        use_rd  = opcode inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h37, 7'h17, 7'h6f};
        use_rs1 = opcode inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63};
        use_rs2 = opcode inside {7'h33, 7'h23, 7'h63};
        legal   = !((use_rd && {1'b0, f_rd} >= reg_lim) || (use_rs1 && {1'b0, f_rs1} >= reg_lim) ||
                    (use_rs2 && {1'b0, f_rs2} >= reg_lim));
    end

    // Lowest-numbered free slot in the pre-edge bitmap
    always_comb begin
        free_idx = '0;
        for (int i = bs - 1; i >= 0; i--)
            if (!slot_valid_q[i]) free_idx = idx_w'(i);
    end

    // Next state: retire only hits occupied slots, so it never collides with the slot being allocated
    always_comb begin
        slot_valid_d = slot_valid_q;
        if (ret_hit) slot_valid_d[retire_index] = 1'b0;
        if (alloc) slot_valid_d[free_idx] = 1'b1;
        count_d        = count_q + cnt_w'(alloc) - cnt_w'(ret_hit);
        wr_en_d        = alloc;
        illegal_d      = accept && !legal;
        buffer_index_d = alloc ? free_idx : buffer_index_q;
        rd_d           = alloc ? (use_rd ? f_rd[reg_w-1:0] : '0) : rd_q;
        rs1_d          = alloc ? (use_rs1 ? f_rs1[reg_w-1:0] : '0) : rs1_q;
        rs2_d          = alloc ? (use_rs2 ? f_rs2[reg_w-1:0] : '0) : rs2_q;
    end

    // Control and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid_q   <= '0;
            count_q        <= '0;
            wr_en_q        <= 1'b0;
            illegal_q      <= 1'b0;
            buffer_index_q <= '0;
            rd_q           <= '0;
            rs1_q          <= '0;
            rs2_q          <= '0;
        end else begin
            slot_valid_q   <= slot_valid_d;
            count_q        <= count_d;
            wr_en_q        <= wr_en_d;
            illegal_q      <= illegal_d;
            buffer_index_q <= buffer_index_d;
            rd_q           <= rd_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
        end
    end

    // Instruction storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (alloc) mem_q[free_idx] <= in_instr;
    end
endmodule
